// File: rtl/orb_host_pkg.sv
// orb_host_pkg: shared constants, state encoding and parameter-word helper for the
// ORB host bridge.
//   Frame limits X_MAX/Y_MAX, pixel width COLOUR_DEPTH, parameter SRAM geometry,
//   derived address/config widths, host_state_t, parameter addresses, START_CMD.
package orb_host_pkg;

    localparam int X_MAX        = 400;
    localparam int Y_MAX        = 400;
    localparam int COLOUR_DEPTH = 24;
    localparam int NUM_PARAMS   = 8;
    localparam int PARAM_DEPTH  = 8;

    // Address widths cover 0..MAX-1; config widths must also hold MAX itself.
    localparam int XW  = $clog2(X_MAX);
    localparam int YW  = $clog2(Y_MAX);
    localparam int WW  = $clog2(X_MAX) + 1;
    localparam int HW  = $clog2(Y_MAX) + 1;
    localparam int PAW = $clog2(NUM_PARAMS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_DRAIN = 3'd5
    } host_state_t;

    localparam logic [PAW-1:0] P_WLO   = 3'd0;
    localparam logic [PAW-1:0] P_WHI   = 3'd1;
    localparam logic [PAW-1:0] P_HLO   = 3'd2;
    localparam logic [PAW-1:0] P_HHI   = 3'd3;
    localparam logic [PAW-1:0] P_KERN  = 3'd4;
    localparam logic [PAW-1:0] P_SIGMA = 3'd5;
    localparam logic [PAW-1:0] P_CTRL  = 3'd7;

    localparam logic [PARAM_DEPTH-1:0] START_CMD = 8'h01;

    // Value written to parameter entry idx during configuration.
    function automatic logic [PARAM_DEPTH-1:0] param_value(
        input logic [PAW-1:0] idx,
        input logic [15:0]    wm1,
        input logic [15:0]    hm1,
        input logic [7:0]     kern,
        input logic [2:0]     sigma
    );
        case (idx)
            P_WLO:   param_value = wm1[7:0];
            P_WHI:   param_value = wm1[15:8];
            P_HLO:   param_value = hm1[7:0];
            P_HHI:   param_value = hm1[15:8];
            P_KERN:  param_value = kern;
            P_SIGMA: param_value = {5'b0, sigma};
            default: param_value = '0;
        endcase
    endfunction

endpackage

// File: rtl/orb_host_bridge_if.sv
// orb_host_bridge_if: host-facing configuration handshake, input pixel stream and
// output pixel stream of the bridge.
//   master: host side (drives cfg_*, s_valid/s_data, m_ready)
//   slave : bridge side (drives cfg_ready, s_ready, m_valid/m_data/m_last)
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both
// high; valid/data hold until accepted, and no ready depends on its own valid.
interface orb_host_bridge_if;
    import orb_host_pkg::*;

    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [WW-1:0]           cfg_width;
    logic [HW-1:0]           cfg_height;
    logic [7:0]              cfg_kernel;
    logic [2:0]              cfg_sigma;

    logic                    s_valid;
    logic                    s_ready;
    logic [COLOUR_DEPTH-1:0] s_data;

    logic                    m_valid;
    logic                    m_ready;
    logic [COLOUR_DEPTH-1:0] m_data;
    logic                    m_last;

    modport master (
        output cfg_valid, cfg_width, cfg_height, cfg_kernel, cfg_sigma,
        output s_valid, s_data, m_ready,
        input  cfg_ready, s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  cfg_valid, cfg_width, cfg_height, cfg_kernel, cfg_sigma,
        input  s_valid, s_data, m_ready,
        output cfg_ready, s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/bridge_skid_fifo.sv
// bridge_skid_fifo: 2-entry FIFO carrying {last, pixel} between the circle SRAM
// read port and the output stream.
//   push/push_data : write side (ignored when full)
//   pop/pop_data   : read side, pop_data is the head entry (ignored when empty)
//   full/empty     : occupancy flags
module bridge_skid_fifo
    import orb_host_pkg::*;
#(
    parameter int W = COLOUR_DEPTH + 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wp_q, wp_d, rp_q, rp_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rp_q];

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (do_push) begin
            mem_d[wp_q] = push_data;
            wp_d        = ~wp_q;
        end
        if (do_pop) begin
            rp_d = ~rp_q;
        end
        cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/orb_host_bridge.sv
// orb_host_bridge: loads a frame configuration and raster pixel stream into the ORB
// core's parameter and image SRAMs, starts the core, waits for img_done, then streams
// the circle-overlay SRAM back to the host.
//   clk, n_rst            : clock, asynchronous active-low reset
//   host                  : cfg handshake, s_* input stream, m_* output stream
//   *_img                 : image SRAM write port
//   *_params              : parameter SRAM write port
//   img_done              : completion pulse from the core (honoured only in WAIT)
//   *_circle, rdat_circle : circle SRAM read port, 1-cycle read latency
//   busy, cfg_err         : not-IDLE flag, sticky rejected-config flag
//   checksum              : byte sum of accepted pixels (HOST_BRIDGE_CHECKSUM_EN)
//   dbg_state             : current FSM state
// Optional feature macro: HOST_BRIDGE_CHECKSUM_EN (undefined: checksum tied to 0).
module orb_host_bridge
    import orb_host_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_rst,
    orb_host_bridge_if.slave        host,
    output logic [XW-1:0]           x_addr_img,
    output logic [YW-1:0]           y_addr_img,
    output logic                    wen_img,
    output logic [COLOUR_DEPTH-1:0] wdat_img,
    output logic [PAW-1:0]          addr_write_params,
    output logic                    wen_params,
    output logic [PARAM_DEPTH-1:0]  wdat_params,
    input  logic                    img_done,
    output logic [XW-1:0]           x_addr_circle,
    output logic [YW-1:0]           y_addr_circle,
    output logic                    ren_circle,
    input  logic [COLOUR_DEPTH-1:0] rdat_circle,
    output logic                    busy,
    output logic                    cfg_err,
    output logic [15:0]             checksum,
    output host_state_t             dbg_state
);

    host_state_t   state_q, state_d;
    logic [WW-1:0] width_q, width_d;
    logic [HW-1:0] height_q, height_d;
    logic [7:0]    kern_q, kern_d;
    logic [2:0]    sigma_q, sigma_d;
    logic          cfg_err_q, cfg_err_d;
    logic [PAW-1:0] pcnt_q, pcnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          rd_done_q, rd_done_d;
    logic          infl_q, infl_d;
    logic          infl_last_q, infl_last_d;

    logic [15:0]   wm1, hm1;
    logic          x_last, y_last, cfg_bad;
    logic          fifo_full, fifo_empty, pop;
    logic [COLOUR_DEPTH:0] fifo_head;
    logic [1:0]    occ;
    logic [2:0]    slots_used;

    assign wm1     = 16'(width_q) - 16'd1;
    assign hm1     = 16'(height_q) - 16'd1;
    assign x_last  = (16'(x_q) == wm1);
    assign y_last  = (16'(y_q) == hm1);
    assign cfg_bad = (host.cfg_width == '0) || (host.cfg_width > WW'(X_MAX)) ||
                     (host.cfg_height == '0) || (host.cfg_height > HW'(Y_MAX));

    // A read is only issued when the FIFO will have room for its data, counting the
    // read already in flight and crediting this cycle's pop.
    assign pop        = host.m_valid && host.m_ready;
    assign occ        = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign slots_used = {1'b0, occ} + {2'b0, infl_q} - {2'b0, pop};

    assign host.m_valid = !fifo_empty;
    assign host.m_last  = fifo_head[COLOUR_DEPTH];
    assign host.m_data  = fifo_head[COLOUR_DEPTH-1:0];
    assign busy         = (state_q != S_IDLE);
    assign cfg_err      = cfg_err_q;
    assign dbg_state    = state_q;

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        kern_d      = kern_q;
        sigma_d     = sigma_q;
        cfg_err_d   = cfg_err_q;
        pcnt_d      = pcnt_q;
        x_d         = x_q;
        y_d         = y_q;
        rd_done_d   = rd_done_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        host.cfg_ready    = 1'b0;
        host.s_ready      = 1'b0;
        wen_img           = 1'b0;
        x_addr_img        = '0;
        y_addr_img        = '0;
        wdat_img          = '0;
        wen_params        = 1'b0;
        addr_write_params = '0;
        wdat_params       = '0;
        ren_circle        = 1'b0;
        x_addr_circle     = '0;
        y_addr_circle     = '0;

        case (state_q)
            S_IDLE: begin
                host.cfg_ready = 1'b1;
                if (host.cfg_valid) begin
                    width_d  = host.cfg_width;
                    height_d = host.cfg_height;
                    kern_d   = host.cfg_kernel;
                    sigma_d  = host.cfg_sigma;
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        pcnt_d    = '0;
                        state_d   = S_CFG;
                    end
                end
            end
            S_CFG: begin
                wen_params        = 1'b1;
                addr_write_params = pcnt_q;
                wdat_params       = param_value(pcnt_q, wm1, hm1, kern_q, sigma_q);
                if (pcnt_q == P_SIGMA) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_LOAD;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            S_LOAD: begin
                host.s_ready = 1'b1;
                if (host.s_valid) begin
                    wen_img    = 1'b1;
                    x_addr_img = x_q;
                    y_addr_img = y_q;
                    wdat_img   = host.s_data;
                    if (x_last) begin
                        x_d = '0;
                        if (y_last) state_d = S_START;
                        else        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_START: begin
                wen_params        = 1'b1;
                addr_write_params = P_CTRL;
                wdat_params       = START_CMD;
                state_d           = S_WAIT;
            end
            S_WAIT: begin
                if (img_done) begin
                    x_d       = '0;
                    y_d       = '0;
                    rd_done_d = 1'b0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!rd_done_q && (slots_used < 3'd2)) begin
                    ren_circle    = 1'b1;
                    x_addr_circle = x_q;
                    y_addr_circle = y_q;
                    infl_d        = 1'b1;
                    infl_last_d   = x_last && y_last;
                    if (x_last) begin
                        x_d = '0;
                        if (y_last) rd_done_d = 1'b1;
                        else        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                if (pop && host.m_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            kern_q      <= '0;
            sigma_q     <= '0;
            cfg_err_q   <= 1'b0;
            pcnt_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rd_done_q   <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            kern_q      <= kern_d;
            sigma_q     <= sigma_d;
            cfg_err_q   <= cfg_err_d;
            pcnt_q      <= pcnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rd_done_q   <= rd_done_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    // Read data returns the cycle after the read, so the in-flight flag is the push.
    bridge_skid_fifo #(.W(COLOUR_DEPTH + 1)) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (infl_q),
        .push_data ({infl_last_q, rdat_circle}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef HOST_BRIDGE_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;
    logic        load_entry;

    assign load_entry = (state_q == S_CFG) && (pcnt_q == P_SIGMA);

    always_comb begin
        checksum_d = checksum_q;
        if (load_entry) begin
            checksum_d = '0;
        end else if (wen_img) begin
            checksum_d = checksum_q + 16'(host.s_data[7:0]) +
                         16'(host.s_data[15:8]) + 16'(host.s_data[23:16]);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_orb_host_bridge.sv
// tb_orb_host_bridge: directed self-checking bench for orb_host_bridge with SRAM
// models for the image, parameter and circle memories.
module tb_orb_host_bridge;
  import orb_host_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic n_rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  orb_host_bridge_if bus();
  logic [XW-1:0]           x_addr_img, x_addr_circle;
  logic [YW-1:0]           y_addr_img, y_addr_circle;
  logic                    wen_img, wen_params, ren_circle, img_done, busy, cfg_err;
  logic [COLOUR_DEPTH-1:0] wdat_img, rdat_circle;
  logic [PAW-1:0]          addr_write_params;
  logic [PARAM_DEPTH-1:0]  wdat_params;
  logic [15:0]             checksum;
  host_state_t             dbg_state;

  orb_host_bridge dut (
    .clk(clk), .n_rst(n_rst), .host(bus.slave),
    .x_addr_img(x_addr_img), .y_addr_img(y_addr_img), .wen_img(wen_img), .wdat_img(wdat_img),
    .addr_write_params(addr_write_params), .wen_params(wen_params), .wdat_params(wdat_params),
    .img_done(img_done), .x_addr_circle(x_addr_circle), .y_addr_circle(y_addr_circle),
    .ren_circle(ren_circle), .rdat_circle(rdat_circle), .busy(busy), .cfg_err(cfg_err),
    .checksum(checksum), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / monitors ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [23:0] img_mem  [16][16];
  logic [23:0] circ_mem [16][16];
  logic [10:0] par_q[$];
  int          par_cyc_q[$];
  logic [24:0] out_q[$];
  int          out_cyc_q[$];
  logic [24:0] exp_q[$];
  int cyc = 0, hs_cyc = -1, last_pix_cyc = -1, done_cyc = -1, first_ren_cyc = -1;
  bit          prev_stall = 1'b0;
  logic [25:0] prev_vec = '0;

  always @(posedge clk) begin
    if (ren_circle && x_addr_circle < 16 && y_addr_circle < 16)
      rdat_circle <= circ_mem[y_addr_circle][x_addr_circle];
  end

  always @(posedge clk) begin
    if (prev_stall) check_eq("m_hold", {bus.m_valid, bus.m_last, bus.m_data}, prev_vec);
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_vec   = {bus.m_valid, bus.m_last, bus.m_data};
    if (bus.cfg_valid && bus.cfg_ready) hs_cyc = cyc;
    if (wen_params) begin
      par_q.push_back({addr_write_params, wdat_params});
      par_cyc_q.push_back(cyc);
    end
    if (wen_img && x_addr_img < 16 && y_addr_img < 16) img_mem[y_addr_img][x_addr_img] = wdat_img;
    if (bus.s_valid && bus.s_ready) last_pix_cyc = cyc;
    if (img_done) begin
      done_cyc = cyc;
      first_ren_cyc = -1;
    end
    if (ren_circle && first_ren_cyc < 0) first_ren_cyc = cyc;
    if (bus.m_valid && bus.m_ready) begin
      out_q.push_back({bus.m_last, bus.m_data});
      out_cyc_q.push_back(cyc);
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_cfg(input int w, input int h, input int k, input int s);
    int t;
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_width = WW'(w);
    bus.cfg_height = HW'(h);
    bus.cfg_kernel = 8'(k);
    bus.cfg_sigma = 3'(s);
    t = 0;
    while (!bus.cfg_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("cfg_ready_wait", t < 100, 1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic stream(input int n, input logic [23:0] base, input logic [23:0] step);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data = base + 24'(i) * step;
      t = 0;
      while (!bus.s_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) check_eq("s_ready_wait", 0, 1);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic check_params(input int w, input int h, input int k, input int s);
    logic [15:0] wm1, hm1;
    logic [7:0]  ev [6];
    wm1 = 16'(w - 1);
    hm1 = 16'(h - 1);
    ev = '{wm1[7:0], wm1[15:8], hm1[7:0], hm1[15:8], 8'(k), {5'b0, 3'(s)}};
    repeat (8) @(negedge clk);
    check_eq("param_count", par_q.size(), 6);
    for (int i = 0; i < 6 && i < par_q.size(); i++) begin
      check_eq("param_word", par_q[i], {3'(i), ev[i]});
      check_eq("param_cycle", par_cyc_q[i], hs_cyc + 1 + i);
    end
    par_q.delete();
    par_cyc_q.delete();
  endtask

  task automatic check_load(input int w, input int h, input logic [23:0] base, input logic [23:0] step);
    repeat (3) @(negedge clk);
    for (int i = 0; i < w * h; i++)
      check_eq("img_word", img_mem[i / w][i % w], base + 24'(i) * step);
    check_eq("start_count", par_q.size(), 1);
    if (par_q.size() > 0) begin
      check_eq("start_word", par_q[0], {3'd7, 8'h01});
      check_eq("start_cycle", par_cyc_q[0], last_pix_cyc + 1);
    end
    check_eq("busy_wait", busy, 1);
    check_eq("state_wait", dbg_state, S_WAIT);
    par_q.delete();
    par_cyc_q.delete();
  endtask

  task automatic drain(input int w, input int h, input bit toggle);
    int n, t;
    logic [24:0] e, o;
    n = w * h;
    out_q.delete();
    out_cyc_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, circ_mem[i / w][i % w]});
    bus.m_ready = !toggle;
    @(negedge clk);
    img_done = 1'b1;
    @(negedge clk);
    img_done = 1'b0;
    t = 0;
    while (out_q.size() < n && t < 400) begin
      @(negedge clk);
      if (toggle) bus.m_ready = ~bus.m_ready;
      t++;
    end
    repeat (4) @(negedge clk);
    check_eq("beat_count", out_q.size(), n);
    check_eq("ren_latency", first_ren_cyc, done_cyc + 1);
    if (!toggle && out_cyc_q.size() == n) begin
      check_eq("first_beat_cycle", out_cyc_q[0], done_cyc + 3);
      for (int i = 1; i < n; i++) check_eq("beat_rate", out_cyc_q[i], out_cyc_q[0] + i);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (out_q.size() > 0) begin
        o = out_q.pop_front();
        check_eq("beat_data", o[23:0], e[23:0]);
        check_eq("beat_last", o[24], e[24]);
      end
    end
    check_eq("busy_after_drain", busy, 0);
    check_eq("state_after_drain", dbg_state, S_IDLE);
    bus.m_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cfg_ready"}, bus.cfg_ready, 1);
    check_eq({tag, "_ready_valid"}, {bus.s_ready, bus.m_valid, bus.m_last}, 0);
    check_eq({tag, "_enables"}, {wen_img, wen_params, ren_circle}, 0);
    check_eq({tag, "_addrs"}, {x_addr_img, y_addr_img, addr_write_params, x_addr_circle, y_addr_circle}, 0);
    check_eq({tag, "_wdata"}, {wdat_img, wdat_params}, 0);
    check_eq({tag, "_busy_err"}, {busy, cfg_err}, 0);
    check_eq({tag, "_checksum"}, checksum, 0);
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] ck_frame1, ck_ones, ck_frame3;

  initial begin
`ifdef HOST_BRIDGE_CHECKSUM_EN
    ck_frame1 = 16'h0042;
    ck_ones   = 16'h05FA;
    ck_frame3 = 16'h00D2;
`else
    ck_frame1 = 16'h0000;
    ck_ones   = 16'h0000;
    ck_frame3 = 16'h0000;
`endif
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        img_mem[y][x]  = '0;
        circ_mem[y][x] = 24'hC00000 + 24'(y * 256 + x);
      end
    n_rst = 1'b0;
    img_done = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_width = '0;
    bus.cfg_height = '0;
    bus.cfg_kernel = '0;
    bus.cfg_sigma = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_held");
    n_rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_released");

    // img_done outside WAIT has no effect
    img_done = 1'b1;
    @(negedge clk);
    img_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_done_busy", busy, 0);
    check_eq("idle_done_no_read", first_ren_cyc, -1);

    // Frame 1: 4x3, kernel 5, sigma 1, pixels 0..11, drain with backpressure
    send_cfg(4, 3, 5, 1);
    check_params(4, 3, 5, 1);
    check_eq("cfg_ready_busy", bus.cfg_ready, 0);
    stream(12, 24'd0, 24'd1);
    check_load(4, 3, 24'd0, 24'd1);
    check_eq("checksum_frame1", checksum, ck_frame1);
    drain(4, 3, 1'b1);

    // Rejected configurations
    send_cfg(0, 3, 5, 1);
    @(negedge clk);
    check_eq("rej_w0_err", cfg_err, 1);
    check_eq("rej_w0_busy", busy, 0);
    send_cfg(401, 3, 5, 1);
    @(negedge clk);
    check_eq("rej_w401_err", cfg_err, 1);
    send_cfg(4, 0, 5, 1);
    @(negedge clk);
    check_eq("rej_h0_err", cfg_err, 1);
    repeat (4) @(negedge clk);
    check_eq("rej_no_params", par_q.size(), 0);
    check_eq("rej_state", dbg_state, S_IDLE);

    // Valid 2x1 frame clears the error; checksum of two all-ones pixels
    send_cfg(2, 1, 3, 2);
    check_eq("accept_clears_err", cfg_err, 0);
    check_params(2, 1, 3, 2);
    stream(2, 24'hFFFFFF, 24'd0);
    check_load(2, 1, 24'hFFFFFF, 24'd0);
    check_eq("checksum_ones", checksum, ck_ones);
    drain(2, 1, 1'b0);

    // Reset in the middle of a load
    send_cfg(4, 3, 7, 3);
    check_params(4, 3, 7, 3);
    stream(5, 24'h500, 24'd1);
    n_rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    check_eq("rst_no_extra_write", img_mem[1][1], 24'd5);
    check_eq("rst_partial_kept", img_mem[1][0], 24'h504);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid_released");

    // Full frame after reset, output drained at full rate
    send_cfg(4, 3, 7, 3);
    check_params(4, 3, 7, 3);
    stream(12, 24'h100, 24'd3);
    check_load(4, 3, 24'h100, 24'd3);
    check_eq("checksum_frame3", checksum, ck_frame3);
    drain(4, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
